xprio_arb: RTL and testbench

Parametrised, registered priority encoder and arbiter with sticky pending requests, per-line enable mask, selectable fixed or round-robin priority, and a valid/ready grant handshake. It is the sequential successor of the core's 32-bit combinational lowest-set-bit encoder, generalised in width and mode. It sits between interrupt and trap sources (or multi-master request lines) and the consumer that services one source per handshake.

---
 rtl/xprio_arb_pkg.sv | 26 ++
 rtl/xprio_arb_if.sv | 28 ++
 rtl/xprio_find.sv | 29 ++
 rtl/xprio_arb.sv | 139 +++++++++++++
 tb/tb_xprio_arb.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/xprio_arb_pkg.sv
// rtl/xprio_arb_pkg.sv - shared mode selectors, FSM state type and helpers for the priority arbiter
`ifndef ARB_FIXED
`define ARB_FIXED 0
`endif
`ifndef ARB_RR
`define ARB_RR 1
`endif

package xprio_arb_pkg;

  // Arbitration modes: fixed picks the lowest eligible line, RR rotates from the pointer
  localparam int ARB_FIXED = `ARB_FIXED;
  localparam int ARB_RR    = `ARB_RR;

  // Grant FSM: IDLE looks for an eligible line, HOLD presents it until accepted
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // Encoded index width; a single line still needs one bit of index
  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/xprio_arb_if.sv
// rtl/xprio_arb_if.sv - grant handshake bundle between the arbiter and the servicing consumer
interface xprio_arb_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
);

  logic             vld_o;
  logic             rdy_i;
  logic [IDX_W-1:0] idx_o;
  logic [WIDTH-1:0] onehot_o;

  // Arbiter side presents the grant and watches the consumer's ready
  modport master (
    output vld_o,
    output idx_o,
    output onehot_o,
    input  rdy_i
  );

  // Consumer side takes the grant and returns ready
  modport slave (
    input  vld_o,
    input  idx_o,
    input  onehot_o,
    output rdy_i
  );

endinterface

// File: rtl/xprio_find.sv
// rtl/xprio_find.sv - combinational lowest-set-bit finder with index and one-hot outputs
module xprio_find
  import xprio_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot
);

  // Scan from the top down so the lowest set bit is the last one written and wins
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found     = 1'b1;
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xprio_arb.sv
// rtl/xprio_arb.sv - registered priority arbiter with sticky pending requests and a held grant
module xprio_arb
  import xprio_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_width(WIDTH),
  parameter int MODE  = ARB_FIXED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [WIDTH-1:0] pend_o,
  xprio_arb_if.master      gnt
);

  arb_state_t       state;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] elig;
  logic [WIDTH-1:0] clr;
  logic             accept;

  logic             vld_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] oh_q;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_oh;

  // Only registered pending bits compete; a fresh request waits one cycle in pend
  assign elig   = pend & mask_i;
  assign accept = (state == ST_HOLD) && gnt.rdy_i;
  assign clr    = accept ? oh_q : '0;

  if (MODE == ARB_RR) begin : g_rr
    logic [IDX_W-1:0] ptr;
    logic [WIDTH-1:0] upper;
    logic             hi_found;
    logic             lo_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic [WIDTH-1:0] hi_oh;
    logic [WIDTH-1:0] lo_oh;

    // Lines at or above the rotation pointer get first pick
    always_comb begin
      upper = '0;
      for (int i = 0; i < WIDTH; i++) begin
        upper[i] = (i >= int'(ptr));
      end
    end

    xprio_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_find_hi (
      .vec    (elig & upper),
      .found  (hi_found),
      .idx    (hi_idx),
      .onehot (hi_oh)
    );

    xprio_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_find_lo (
      .vec    (elig),
      .found  (lo_found),
      .idx    (lo_idx),
      .onehot (lo_oh)
    );

    // Nothing at or above the pointer means wrap to the lowest eligible line
    assign sel_found = hi_found | lo_found;
    assign sel_idx   = hi_found ? hi_idx : lo_idx;
    assign sel_oh    = hi_found ? hi_oh  : lo_oh;

    // Move the pointer just past each accepted line so it gets lowest priority next
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr <= '0;
      end else if (accept) begin
        ptr <= (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end else begin : g_fixed
    xprio_find #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_find (
      .vec    (elig),
      .found  (sel_found),
      .idx    (sel_idx),
      .onehot (sel_oh)
    );
  end

  // Pending bits latch every request regardless of mask; a same-cycle request beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr) | req_i;
    end
  end

  // Grant FSM: capture a selection in IDLE, hold it unchanged until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      vld_q <= 1'b0;
      idx_q <= '0;
      oh_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            state <= ST_HOLD;
            vld_q <= 1'b1;
            idx_q <= sel_idx;
            oh_q  <= sel_oh;
          end
        end
        ST_HOLD: begin
          if (gnt.rdy_i) begin
            state <= ST_IDLE;
            vld_q <= 1'b0;
            idx_q <= '0;
            oh_q  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          vld_q <= 1'b0;
          idx_q <= '0;
          oh_q  <= '0;
        end
      endcase
    end
  end

  assign gnt.vld_o    = vld_q;
  assign gnt.idx_o    = idx_q;
  assign gnt.onehot_o = oh_q;
  assign pend_o       = pend;

endmodule

// File: tb/tb_xprio_arb.sv
// tb/tb_xprio_arb.sv - self-checking bench for xprio_arb in fixed and round-robin modes
module tb_xprio_arb;
  import xprio_arb_pkg::*;

  localparam int W  = 8;
  localparam int IW = 3;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] req   = '0;
  logic [W-1:0] mask  = '1;
  logic         rdy   = 1'b0;
  logic [W-1:0] pend_f;
  logic [W-1:0] pend_r;

  int passed = 0;
  int total  = 0;

  xprio_arb_if #(.WIDTH(W), .IDX_W(IW)) gf ();
  xprio_arb_if #(.WIDTH(W), .IDX_W(IW)) gr ();

  assign gf.rdy_i = rdy;
  assign gr.rdy_i = rdy;

  xprio_arb #(.WIDTH(W), .IDX_W(IW), .MODE(ARB_FIXED)) dut_f (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .mask_i (mask),
    .pend_o (pend_f),
    .gnt    (gf)
  );

  xprio_arb #(.WIDTH(W), .IDX_W(IW), .MODE(ARB_RR)) dut_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .mask_i (mask),
    .pend_o (pend_r),
    .gnt    (gr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] m;
    logic         rd;
    logic         vf;
    int           idf;
    logic         vr;
    int           idr;
    logic [W-1:0] pf;
    logic [W-1:0] pr;
  } vec_t;

  vec_t tbl [20];

  // reference model, index 0 = fixed, 1 = round-robin
  bit [W-1:0] mpend [2];
  bit         mg    [2];
  int         midx  [2];
  int         mptr  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mpend[d] = '0;
      mg[d]    = 1'b0;
      midx[d]  = 0;
      mptr[d]  = 0;
    end
  endtask

  task automatic model_step(input logic [W-1:0] r, input logic [W-1:0] m, input logic rd);
    for (int d = 0; d < 2; d++) begin
      bit [W-1:0] np;
      bit         ng;
      int         ni;
      int         nptr;
      np   = mpend[d];
      ng   = mg[d];
      ni   = midx[d];
      nptr = mptr[d];
      if (mg[d]) begin
        if (rd) begin
          np[midx[d]] = 1'b0;
          ng = 1'b0;
          ni = 0;
          if (d == 1) nptr = (midx[d] + 1) % W;
        end
      end else begin
        for (int k = 0; k < W; k++) begin
          int j;
          j = (mptr[d] + k) % W;
          if (mpend[d][j] && m[j]) begin
            ng = 1'b1;
            ni = j;
            break;
          end
        end
      end
      for (int i = 0; i < W; i++) begin
        if (r[i]) np[i] = 1'b1;
      end
      mpend[d] = np;
      mg[d]    = ng;
      midx[d]  = ni;
      mptr[d]  = nptr;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic chk_grant(input string tag, input int d, input bit ev, input int ei, input int ep);
    int eidx;
    int eoh;
    eidx = ev ? ei : 0;
    eoh  = ev ? (1 << ei) : 0;
    if (d == 0) begin
      chk({tag, " vld_f"}, int'(gf.vld_o), int'(ev));
      chk({tag, " idx_f"}, int'(gf.idx_o), eidx);
      chk({tag, " oh_f"}, int'(gf.onehot_o), eoh);
      chk({tag, " pend_f"}, int'(pend_f), ep);
    end else begin
      chk({tag, " vld_r"}, int'(gr.vld_o), int'(ev));
      chk({tag, " idx_r"}, int'(gr.idx_o), eidx);
      chk({tag, " oh_r"}, int'(gr.onehot_o), eoh);
      chk({tag, " pend_r"}, int'(pend_r), ep);
    end
  endtask

  task automatic cyc(input logic [W-1:0] r, input logic [W-1:0] m, input logic rd);
    req  = r;
    mask = m;
    rdy  = rd;
    model_step(r, m, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic [W-1:0] r, input logic [W-1:0] m, input logic rd,
                      input bit vf, input int idf, input bit vr, input int idr,
                      input logic [W-1:0] pf, input logic [W-1:0] pr);
    cyc(r, m, rd);
    chk_grant(tag, 0, vf, idf, int'(pf));
    chk_grant(tag, 1, vr, idr, int'(pr));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_grant("reset", 0, 1'b0, 0, 0);
    chk_grant("reset", 1, 1'b0, 0, 0);
    rst_n = 1'b1;

    // pulse A4 then drain; then a held 03 request
    tbl[0]  = '{8'hA4, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'hA4, 8'hA4};
    tbl[1]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 2, 1'b1, 2, 8'hA4, 8'hA4};
    tbl[2]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'hA0, 8'hA0};
    tbl[3]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 5, 1'b1, 5, 8'hA0, 8'hA0};
    tbl[4]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h80, 8'h80};
    tbl[5]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 7, 1'b1, 7, 8'h80, 8'h80};
    tbl[6]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00};
    tbl[7]  = '{8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00};
    tbl[8]  = '{8'h03, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h03, 8'h03};
    tbl[9]  = '{8'h03, 8'hFF, 1'b1, 1'b1, 0, 1'b1, 0, 8'h03, 8'h03};
    tbl[10] = '{8'h03, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h03, 8'h03};
    tbl[11] = '{8'h03, 8'hFF, 1'b1, 1'b1, 0, 1'b1, 1, 8'h03, 8'h03};
    tbl[12] = '{8'h03, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h03, 8'h03};
    tbl[13] = '{8'h03, 8'hFF, 1'b1, 1'b1, 0, 1'b1, 0, 8'h03, 8'h03};
    tbl[14] = '{8'h03, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h03, 8'h03};
    tbl[15] = '{8'h03, 8'hFF, 1'b1, 1'b1, 0, 1'b1, 1, 8'h03, 8'h03};
    tbl[16] = '{8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h02, 8'h01};
    tbl[17] = '{8'h00, 8'hFF, 1'b1, 1'b1, 1, 1'b1, 0, 8'h02, 8'h01};
    tbl[18] = '{8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00};
    tbl[19] = '{8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00};

    for (int i = 0; i < 20; i++) begin
      step($sformatf("tbl%0d", i), tbl[i].r, tbl[i].m, tbl[i].rd,
           tbl[i].vf, tbl[i].idf, tbl[i].vr, tbl[i].idr, tbl[i].pf, tbl[i].pr);
    end

    // round-robin wrap: grant 5 moves ptr to 6, pend 09 then gives 0 and 3
    step("wrap_a", 8'h20, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h20, 8'h20);
    step("wrap_b", 8'h00, 8'hFF, 1'b1, 1'b1, 5, 1'b1, 5, 8'h20, 8'h20);
    step("wrap_c", 8'h09, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h09, 8'h09);
    step("wrap_d", 8'h00, 8'hFF, 1'b1, 1'b1, 0, 1'b1, 0, 8'h09, 8'h09);
    step("wrap_e", 8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h08, 8'h08);
    step("wrap_f", 8'h00, 8'hFF, 1'b1, 1'b1, 3, 1'b1, 3, 8'h08, 8'h08);
    step("wrap_g", 8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00);

    // backpressure: grant 4 held while its mask drops and line 1 arrives
    step("bp_a", 8'h10, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0, 8'h10, 8'h10);
    step("bp_b", 8'h00, 8'hFF, 1'b0, 1'b1, 4, 1'b1, 4, 8'h10, 8'h10);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("bp_hold%0d", i), 8'h02, 8'hEF, 1'b0, 1'b1, 4, 1'b1, 4, 8'h12, 8'h12);
    end
    step("bp_acc", 8'h00, 8'hEF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h02, 8'h02);
    step("bp_next", 8'h00, 8'hEF, 1'b1, 1'b1, 1, 1'b1, 1, 8'h02, 8'h02);
    step("bp_done", 8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00);

    // accept of line 3 coinciding with a new request on line 3
    step("sim_a", 8'h08, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h08, 8'h08);
    step("sim_b", 8'h00, 8'hFF, 1'b1, 1'b1, 3, 1'b1, 3, 8'h08, 8'h08);
    step("sim_c", 8'h08, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h08, 8'h08);
    step("sim_d", 8'h00, 8'hFF, 1'b1, 1'b1, 3, 1'b1, 3, 8'h08, 8'h08);
    step("sim_e", 8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00);

    // reset while a grant is presented
    step("rst_a", 8'hF0, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 0, 8'hF0, 8'hF0);
    step("rst_b", 8'h00, 8'hFF, 1'b0, 1'b1, 4, 1'b1, 4, 8'hF0, 8'hF0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_grant("rst_async", 0, 1'b0, 0, 0);
    chk_grant("rst_async", 1, 1'b0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("rst_idle%0d", i), 8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00);
    end

    // randomized traffic against the reference model
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] rr;
      logic [W-1:0] mm;
      logic         rd;
      rr = W'($urandom & $urandom & $urandom);
      mm = W'($urandom | $urandom);
      rd = ($urandom % 4) != 0;
      cyc(rr, mm, rd);
      chk_grant($sformatf("rnd%0d", n), 0, mg[0], midx[0], int'(mpend[0]));
      chk_grant($sformatf("rnd%0d", n), 1, mg[1], midx[1], int'(mpend[1]));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
